// File: rtl/ann_pkg.sv
// Shared constants, FSM state type and saturation helper for the sequenced 6-3-2-1 ReLU network.
package ann_pkg;

  localparam int unsigned ACC_W   = 8;
  localparam int unsigned W_W     = 4;
  localparam int unsigned B_W     = 3;
  localparam int unsigned IN_W    = 3;
  localparam int unsigned N_STEPS = 14;
  localparam int unsigned STEP_W  = 4;
  localparam int unsigned CFG_AW  = 4;
  localparam int unsigned N_W     = 9;
  localparam int unsigned N_B     = 6;
  localparam int unsigned N_IN    = 6;

  localparam logic [CFG_AW-1:0] CFG_W_LAST  = 4'd8;
  localparam logic [CFG_AW-1:0] CFG_B_FIRST = 4'd9;
  localparam logic [CFG_AW-1:0] CFG_NOP     = 4'd15;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic signed [W_W-1:0] W_RST [N_W] = '{
    W_W'(4), W_W'(-3), W_W'(1), W_W'(2), W_W'(-2), W_W'(4), W_W'(1), W_W'(-3), W_W'(2)
  };
  localparam logic signed [B_W-1:0] B_RST [N_B] = '{
    B_W'(2), B_W'(-2), B_W'(1), B_W'(-1), B_W'(2), B_W'(-3)
  };

  localparam logic signed [2*ACC_W-1:0] SAT_MAX = (2*ACC_W)'((1 << (ACC_W-1)) - 1);
  localparam logic signed [2*ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  // Clamp a double-width signed value into the accumulator range.
  function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [2*ACC_W-1:0] v);
    if (v > SAT_MAX) return ACC_W'(SAT_MAX);
    if (v < SAT_MIN) return ACC_W'(SAT_MIN);
    return ACC_W'(v);
  endfunction

endpackage

// File: rtl/ann_mac.sv
// Shared multiply-accumulate: product plus bias-or-accumulator, with wrap or clamp
// (ANN_SAT_EN) and a ReLU view of the result.
module ann_mac
  import ann_pkg::*;
(
  input  logic signed [ACC_W-1:0] op_a,
  input  logic signed [ACC_W-1:0] op_w,
  input  logic signed [ACC_W-1:0] bias,
  input  logic signed [ACC_W-1:0] acc,
  input  logic                    first,
  output logic signed [ACC_W-1:0] acc_next_c,
  output logic signed [ACC_W-1:0] relu_c
);

  logic signed [ACC_W-1:0]   base;
  logic signed [2*ACC_W-1:0] prod_full;
  logic signed [ACC_W-1:0]   prod;
  logic signed [ACC_W:0]     sum_full;

  always_comb begin
    base      = first ? bias : acc;
    prod_full = (2*ACC_W)'(op_a) * (2*ACC_W)'(op_w);
`ifdef ANN_SAT_EN
    prod       = sat_acc(prod_full);
    sum_full   = (ACC_W+1)'(base) + (ACC_W+1)'(prod);
    acc_next_c = sat_acc((2*ACC_W)'(sum_full));
`else
    prod       = ACC_W'(prod_full);
    sum_full   = (ACC_W+1)'(base) + (ACC_W+1)'(prod);
    acc_next_c = ACC_W'(sum_full);
`endif
    relu_c = acc_next_c[ACC_W-1] ? '0 : acc_next_c;
  end

endmodule

// File: rtl/ann_mac_seq.sv
// Sequenced 6-3-2-1 ReLU network: one MAC time-shared over 14 steps, programmable
// weights/biases. Define ANN_SAT_EN for saturating instead of wrapping arithmetic.
module ann_mac_seq
  import ann_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic signed [IN_W-1:0] a1,
  input  logic signed [IN_W-1:0] a2,
  input  logic signed [IN_W-1:0] a3,
  input  logic signed [IN_W-1:0] a4,
  input  logic signed [IN_W-1:0] a5,
  input  logic signed [IN_W-1:0] a6,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ACC_W-1:0]       fop,
  input  logic                   cfg_we,
  input  logic [CFG_AW-1:0]      cfg_addr,
  input  logic [W_W-1:0]         cfg_wdata,
  output logic                   busy
);

  state_t state, state_d;
  logic [STEP_W-1:0] step;
  logic signed [ACC_W-1:0] acc, ay1, ay2, ay3, az1, az2;
  logic signed [IN_W-1:0]  a_q [N_IN];
  logic signed [W_W-1:0]   w   [N_W];
  logic signed [B_W-1:0]   b   [N_B];

  logic signed [ACC_W-1:0] op_a, op_w, bias, acc_next_c, relu_c;
  logic first;
  logic accept;

  assign accept = (state == S_IDLE) && in_valid;

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:  if (in_valid) state_d = S_CALC;
      S_CALC:  if (step == STEP_W'(N_STEPS-1)) state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_d;
      in_ready  <= (state_d == S_IDLE);
      out_valid <= (state_d == S_DONE);
      busy      <= (state_d == S_CALC);
    end
  end

  // Step decode: operand select, bias select and neuron-start flag.
  always_comb begin
    op_a  = '0;
    op_w  = '0;
    bias  = '0;
    first = 1'b0;
    case (step)
      4'd0:  begin op_a = ACC_W'(a_q[0]); op_w = ACC_W'(w[0]); bias = ACC_W'(b[0]); first = 1'b1; end
      4'd1:  begin op_a = ACC_W'(a_q[1]); op_w = ACC_W'(w[1]); end
      4'd2:  begin op_a = ACC_W'(a_q[2]); op_w = ACC_W'(w[2]); bias = ACC_W'(b[1]); first = 1'b1; end
      4'd3:  begin op_a = ACC_W'(a_q[3]); op_w = ACC_W'(w[3]); end
      4'd4:  begin op_a = ACC_W'(a_q[4]); op_w = ACC_W'(w[4]); bias = ACC_W'(b[2]); first = 1'b1; end
      4'd5:  begin op_a = ACC_W'(a_q[5]); op_w = ACC_W'(w[5]); end
      4'd6:  begin op_a = ay1; op_w = ACC_W'(w[6]); bias = ACC_W'(b[3]); first = 1'b1; end
      4'd7:  begin op_a = ay2; op_w = ACC_W'(w[6]); end
      4'd8:  begin op_a = ay3; op_w = ACC_W'(w[6]); end
      4'd9:  begin op_a = ay1; op_w = ACC_W'(w[7]); bias = ACC_W'(b[4]); first = 1'b1; end
      4'd10: begin op_a = ay2; op_w = ACC_W'(w[7]); end
      4'd11: begin op_a = ay3; op_w = ACC_W'(w[7]); end
      4'd12: begin op_a = az1; op_w = ACC_W'(w[8]); bias = ACC_W'(b[5]); first = 1'b1; end
      4'd13: begin op_a = az2; op_w = ACC_W'(w[8]); end
      default: ;
    endcase
  end

  ann_mac u_mac (
    .op_a       (op_a),
    .op_w       (op_w),
    .bias       (bias),
    .acc        (acc),
    .first      (first),
    .acc_next_c (acc_next_c),
    .relu_c     (relu_c)
  );

  // Datapath, activation capture on each neuron's last step, and config port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step <= '0;
      acc  <= '0;
      ay1  <= '0;
      ay2  <= '0;
      ay3  <= '0;
      az1  <= '0;
      az2  <= '0;
      fop  <= '0;
      for (int i = 0; i < N_IN; i++) a_q[i] <= '0;
      for (int i = 0; i < N_W; i++)  w[i]   <= W_RST[i];
      for (int i = 0; i < N_B; i++)  b[i]   <= B_RST[i];
    end else begin
      if (accept) begin
        a_q[0] <= a1;
        a_q[1] <= a2;
        a_q[2] <= a3;
        a_q[3] <= a4;
        a_q[4] <= a5;
        a_q[5] <= a6;
        step   <= '0;
      end else if (state == S_CALC) begin
        acc  <= acc_next_c;
        step <= step + STEP_W'(1);
        case (step)
          4'd1:    ay1 <= relu_c;
          4'd3:    ay2 <= relu_c;
          4'd5:    ay3 <= relu_c;
          4'd8:    az1 <= relu_c;
          4'd11:   az2 <= relu_c;
          4'd13:   fop <= relu_c;
          default: ;
        endcase
      end
      if (cfg_we && !busy) begin
        if (cfg_addr <= CFG_W_LAST) w[cfg_addr] <= cfg_wdata;
        else if (cfg_addr != CFG_NOP) b[3'(cfg_addr - CFG_B_FIRST)] <= cfg_wdata[B_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_ann_mac_seq.sv
// Directed bench for ann_mac_seq with hand-computed results (ANN_SAT_EN-aware).
module tb_ann_mac_seq;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic signed [2:0] a1, a2, a3, a4, a5, a6;
  logic              out_valid;
  logic              out_ready;
  logic [7:0]        fop;
  logic              cfg_we;
  logic [3:0]        cfg_addr;
  logic [3:0]        cfg_wdata;
  logic              busy;

  int checks = 0;
  int errors = 0;
  int cyc;
  int exp_p2;

  ann_mac_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a1        (a1),
    .a2        (a2),
    .a3        (a3),
    .a4        (a4),
    .a5        (a5),
    .a6        (a6),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .fop       (fop),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_in(input int x1, input int x2, input int x3,
                        input int x4, input int x5, input int x6);
    a1 = 3'(x1); a2 = 3'(x2); a3 = 3'(x3);
    a4 = 3'(x4); a5 = 3'(x5); a6 = 3'(x6);
  endtask

  // Present a sample and return at the negedge just after the accept edge.
  task automatic accept_sample();
    int n;
    n = 0;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int c);
    c = 0;
    while (!out_valid && c < 40) begin
      @(negedge clk);
      c++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic cfg_write(input int addr, input int data);
    cfg_we    = 1'b1;
    cfg_addr  = 4'(addr);
    cfg_wdata = 4'(data);
    @(negedge clk);
    cfg_we    = 1'b0;
  endtask

  initial begin
`ifdef ANN_SAT_EN
    exp_p2 = 89;
`else
    exp_p2 = 67;
`endif
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    set_in(0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_fop", 32'(fop), 0);
    check("rst_busy", 32'(busy), 0);
    rst = 1'b0;
    @(negedge clk);

    // All ones with reset defaults
    set_in(1, 1, 1, 1, 1, 1);
    accept_sample();
    check("ones_busy", 32'(busy), 1);
    check("ones_in_ready_calc", 32'(in_ready), 0);
    wait_out(cyc);
    check("ones_latency", 32'(cyc), 14);
    check("ones_fop", 32'(fop), 9);
    check("ones_done_in_ready", 32'(in_ready), 0);
    check("ones_done_busy", 32'(busy), 0);
    consume();
    check("ones_back_idle", 32'(in_ready), 1);

    // Mixed-sign pattern exercising the z2 wrap/clamp
    set_in(3, -4, 0, 0, -4, 3);
    accept_sample();
    wait_out(cyc);
    check("p2_latency", 32'(cyc), 14);
    check("p2_fop", 32'(fop), 32'(exp_p2));
    consume();

    // Writes while busy are dropped
    set_in(1, 1, 1, 1, 1, 1);
    accept_sample();
    cfg_write(15, 1);
    cfg_write(8, 1);
    wait_out(cyc);
    check("busywr_fop", 32'(fop), 9);
    consume();

    // Idle write of w9, then hold the result in DONE
    cfg_write(8, 1);
    accept_sample();
    wait_out(cyc);
    check("w9_latency", 32'(cyc), 14);
    check("w9_fop", 32'(fop), 3);
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0);
      @(negedge clk);
      check("hold_out_valid", 32'(out_valid), 1);
      check("hold_fop", 32'(fop), 3);
      check("hold_in_ready", 32'(in_ready), 0);
    end
    in_valid = 1'b0;
    consume();
    check("hold_release_in_ready", 32'(in_ready), 1);
    check("hold_no_queue_busy", 32'(busy), 0);

    // Reset during step 7
    accept_sample();
    repeat (7) @(negedge clk);
    check("pre_rst_busy", 32'(busy), 1);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 32'(out_valid), 0);
    check("midrst_fop", 32'(fop), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_in_ready", 32'(in_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    accept_sample();
    wait_out(cyc);
    check("postrst_fop", 32'(fop), 9);
    consume();

    // Back-to-back with out_ready held high and in_valid held high
    out_ready = 1'b1;
    set_in(1, 1, 1, 1, 1, 1);
    in_valid = 1'b1;
    @(negedge clk);
    check("b2b_first_busy", 32'(busy), 1);
    set_in(3, -4, 0, 0, -4, 3);
    wait_out(cyc);
    check("b2b_first_latency", 32'(cyc), 14);
    check("b2b_first_fop", 32'(fop), 9);
    check("b2b_done_in_ready", 32'(in_ready), 0);
    @(negedge clk);
    check("b2b_idle_in_ready", 32'(in_ready), 1);
    check("b2b_idle_busy", 32'(busy), 0);
    check("b2b_idle_out_valid", 32'(out_valid), 0);
    @(negedge clk);
    in_valid = 1'b0;
    check("b2b_second_busy", 32'(busy), 1);
    out_ready = 1'b0;
    wait_out(cyc);
    check("b2b_second_latency", 32'(cyc), 14);
    check("b2b_second_fop", 32'(fop), 32'(exp_p2));
    consume();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ann_mac_seq.md
Name: ann_mac_seq

Overview:
- Sequenced, resource-shared implementation of the team's 6-3-2-1 ReLU network: one 8-bit multiply-accumulate unit is time-multiplexed over all 14 products.
- Sample in via valid/ready, result out via valid/ready; the 9 weights and 6 biases are runtime-programmable through a config write port.
- Sits between the sample source and the classifier consumer and replaces the fully parallel combinational datapath where area matters.

Parameters:
- ACC_W, 8, accumulator/activation width in bits (two's complement).
- W_W, 4, weight width in bits (signed).
- B_W, 3, bias width in bits (signed).
- IN_W, 3, per-input width in bits (signed).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  sample available.
- in_ready  out  1  block can accept a sample.
- a1..a6  in  IN_W each  signed inputs, sampled on in_valid&&in_ready.
- out_valid  out  1  fop holds a result.
- out_ready  in  1  consumer accepts the result.
- fop  out  ACC_W  final ReLU output (always >= 0).
- cfg_we  in  1  config write strobe.
- cfg_addr  in  4  0..8 = w1..w9; 9..14 = b1..b6; 15 = no-op.
- cfg_wdata  in  W_W  write data; biases take the low B_W bits.
- busy  out  1  high in CALC.

Behaviour:
- Reset (async, any time including mid-calculation):
  - state=IDLE; in_ready=1, out_valid=0, fop=0, busy=0; step counter, accumulator and activations cleared.
  - Weights reset to w1..w9 = 4,-3,1,2,-2,4,1,-3,2; biases b1..b6 = 2,-2,1,-1,2,-3.
- FSM IDLE -> CALC -> DONE -> IDLE.
  - IDLE: in_ready=1. On in_valid at an edge, latch a1..a6, step=0, go to CALC.
  - CALC: one product per cycle for steps 0..13. After step 13 go to DONE.
  - DONE: out_valid=1, fop stable. On out_ready go to IDLE. in_ready=0 in DONE; there is no same-cycle restart.
- Latency: the accept edge is E0, step k completes on edge E(k+1), and out_valid rises after E14. A sample is therefore 14 cycles in CALC plus at least 1 cycle in DONE.
- Step schedule (neuron: products; bias added on the neuron's first step, ReLU applied on its last):
  - steps 0-1: y1 = a1*w1, a2*w2 + b1.
  - steps 2-3: y2 = a3*w3, a4*w4 + b2.
  - steps 4-5: y3 = a5*w5, a6*w6 + b3.
  - steps 6-8: z1 = ay1*w7, ay2*w7, ay3*w7 + b4.
  - steps 9-11: z2 = ay1*w8, ay2*w8, ay3*w8 + b5.
  - steps 12-13: op = az1*w9, az2*w9 + b6.
- Activation registers: ay1..ay3, az1..az2. fop is loaded with ReLU(op) on step 13.
- Arithmetic:
  - Operands are sign-extended to ACC_W.
  - Each product is truncated to ACC_W.
  - acc_next = (first step ? sext(bias) : acc) + product, truncated to ACC_W (wrap).
  - ReLU: result = (value > 0, signed) ? value : 0.
- Config writes:
  - Take effect on the edge where cfg_we=1 and busy=0.
  - Ignored while busy=1, so a calculation always uses a consistent weight set.
  - A write to addr 15 is ignored.
  - A write in the same cycle a sample is accepted is applied, and the new value is used by that sample.
- in_valid while not in IDLE is ignored (no queueing). The source must hold its data until it sees in_ready.

Optional Feature:
- ANN_SAT_EN defined: every product and every accumulate clamps to [-2^(ACC_W-1), 2^(ACC_W-1)-1] instead of wrapping.
- Undefined: plain two's-complement wrap, bit-exact with the parallel datapath.

Decomposition:
- Shared package ann_pkg holds:
  - the ACC_W/W_W/B_W/IN_W defaults;
  - the FSM state enum;
  - step-count constant N_STEPS=14;
  - cfg address constants;
  - reset weight/bias constants.
- One sub-module, ann_mac: combinational multiply plus add, first-step bias select, wrap/saturate (ANN_SAT_EN) and ReLU helper output.
- Step decode (operand-mux and last-step flags) stays in ann_mac_seq.

Test Plan:
- Reset defaults, all inputs = 1 -> out_valid rises exactly 14 cycles after the accept edge, fop=9.
- Default weights; a1=3, a2=-4, a3=0, a4=0, a5=-4, a6=3 -> fop=67 (z2 wraps -139 -> 117). With ANN_SAT_EN, fop=89.
- Write cfg_addr=15 and w9 (addr 8)=1 while busy, then w9=1 while idle; run with all inputs = 1 -> the busy writes have no effect, then fop=3.
- Hold out_ready=0 for 5 cycles in DONE -> fop and out_valid stable; in_valid pulses ignored; in_ready=0 throughout.
- Assert rst at step 7 -> all outputs 0 immediately, weights at defaults; next sample (all 1) -> fop=9.
- Back-to-back samples with out_ready=1 -> a second accept occurs no earlier than the cycle after DONE, and the second result is correct.
